// File: rtl/simd_proc_ctrl.sv
// Per-processor SIMD front-end: receives LD/LD/INFO/STORE from the issuer, then runs an
// element-wise vector op over a single-port request/grant memory interface.
module simd_proc_ctrl #(
  parameter int unsigned ADDR_WIDTH  = 16,
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned COUNT_WIDTH = 8,
  parameter int unsigned OP_WIDTH    = 2
) (
  input  logic                  i_clk,
  input  logic                  i_rstn,
  input  logic                  i_en,
  input  logic                  i_ack,
  input  logic [ADDR_WIDTH+1:0] i_instr,
  output logic                  o_busy,
  output logic                  o_finish,
  output logic                  o_error,
  output logic                  o_mem_req,
  output logic                  o_mem_we,
  output logic [ADDR_WIDTH-1:0] o_mem_addr,
  output logic [DATA_WIDTH-1:0] o_mem_wdata,
  input  logic                  i_mem_gnt,
  input  logic                  i_mem_rvalid,
  input  logic [DATA_WIDTH-1:0] i_mem_rdata
);

  localparam logic [1:0] INSTR_LD    = 2'd1;
  localparam logic [1:0] INSTR_INFO  = 2'd2;
  localparam logic [1:0] INSTR_STORE = 2'd3;

  localparam int unsigned IDX_WIDTH  = COUNT_WIDTH + 1;
  localparam int unsigned INFO_WIDTH = COUNT_WIDTH + OP_WIDTH;

  typedef enum logic [3:0] {
    StIdle, StRxLd0, StRxLd1, StRxInfo, StRxSt,
    StRdA, StWaA, StRdB, StWaB, StWr, StDone
  } state_e;

  state_e                 state_q, state_d;
  logic [ADDR_WIDTH-1:0]  addr_a_q, addr_a_d;
  logic [ADDR_WIDTH-1:0]  addr_b_q, addr_b_d;
  logic [ADDR_WIDTH-1:0]  addr_w_q, addr_w_d;
  logic [COUNT_WIDTH-1:0] count_q, count_d;
  logic [OP_WIDTH-1:0]    op_q, op_d;
  logic [IDX_WIDTH-1:0]   idx_q, idx_d;
  logic [DATA_WIDTH-1:0]  a_q, a_d;
  logic [DATA_WIDTH-1:0]  b_q, b_d;
  logic                   error_q, error_d;

  logic [1:0]             instr_type;
  logic [ADDR_WIDTH-1:0]  payload;
  logic [INFO_WIDTH-1:0]  info;
  logic [IDX_WIDTH-1:0]   idx_inc;
  logic [ADDR_WIDTH-1:0]  idx_addr;
  logic [DATA_WIDTH-1:0]  result;

  assign instr_type = i_instr[ADDR_WIDTH+1 -: 2];
  assign payload    = i_instr[ADDR_WIDTH-1:0];
  assign info       = payload[ADDR_WIDTH-1 -: INFO_WIDTH];
  assign idx_inc    = idx_q + IDX_WIDTH'(1);
  assign idx_addr   = ADDR_WIDTH'(idx_q);

  always_comb begin
    result = '0;
    case (op_q)
      OP_WIDTH'(0): result = a_q + b_q;
      OP_WIDTH'(1): result = a_q - b_q;
      OP_WIDTH'(2): result = a_q * b_q;
      default:      result = a_q ^ b_q;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state_q  <= StIdle;
      addr_a_q <= '0;
      addr_b_q <= '0;
      addr_w_q <= '0;
      count_q  <= '0;
      op_q     <= '0;
      idx_q    <= '0;
      a_q      <= '0;
      b_q      <= '0;
      error_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      addr_a_q <= addr_a_d;
      addr_b_q <= addr_b_d;
      addr_w_q <= addr_w_d;
      count_q  <= count_d;
      op_q     <= op_d;
      idx_q    <= idx_d;
      a_q      <= a_d;
      b_q      <= b_d;
      error_q  <= error_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    addr_a_d = addr_a_q;
    addr_b_d = addr_b_q;
    addr_w_d = addr_w_q;
    count_d  = count_q;
    op_d     = op_q;
    idx_d    = idx_q;
    a_d      = a_q;
    b_d      = b_q;
    error_d  = error_q;
    unique case (state_q)
      StIdle: if (i_en) state_d = StRxLd0;
      StRxLd0: if (i_ack) begin
        if (instr_type == INSTR_LD) begin
          addr_a_d = payload;
          state_d  = StRxLd1;
        end else begin
          error_d = 1'b1;
          state_d = StDone;
        end
      end
      StRxLd1: if (i_ack) begin
        if (instr_type == INSTR_LD) begin
          addr_b_d = payload;
          state_d  = StRxInfo;
        end else begin
          error_d = 1'b1;
          state_d = StDone;
        end
      end
      StRxInfo: if (i_ack) begin
        if (instr_type == INSTR_INFO) begin
          {count_d, op_d} = info;
          state_d         = StRxSt;
        end else begin
          error_d = 1'b1;
          state_d = StDone;
        end
      end
      StRxSt: if (i_ack) begin
        if (instr_type == INSTR_STORE) begin
          addr_w_d = payload;
          idx_d    = '0;
          state_d  = (count_q == '0) ? StDone : StRdA;
        end else begin
          error_d = 1'b1;
          state_d = StDone;
        end
      end
      StRdA: if (i_mem_gnt) state_d = StWaA;
      // Read data is only taken in the cycle after the grant, never with it.
      StWaA: if (i_mem_rvalid) begin
        a_d     = i_mem_rdata;
        state_d = StRdB;
      end
      StRdB: if (i_mem_gnt) state_d = StWaB;
      StWaB: if (i_mem_rvalid) begin
        b_d     = i_mem_rdata;
        state_d = StWr;
      end
      StWr: if (i_mem_gnt) begin
        idx_d   = idx_inc;
        state_d = (idx_inc == {1'b0, count_q}) ? StDone : StRdA;
      end
      StDone: if (i_ack) begin
        error_d = 1'b0;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    o_busy      = (state_q != StIdle);
    o_finish    = (state_q == StDone);
    o_error     = (state_q == StDone) && error_q;
    o_mem_req   = 1'b0;
    o_mem_we    = 1'b0;
    o_mem_addr  = '0;
    o_mem_wdata = '0;
    case (state_q)
      StRdA: begin
        o_mem_req  = 1'b1;
        o_mem_addr = addr_a_q + idx_addr;
      end
      StRdB: begin
        o_mem_req  = 1'b1;
        o_mem_addr = addr_b_q + idx_addr;
      end
      StWr: begin
        o_mem_req   = 1'b1;
        o_mem_we    = 1'b1;
        o_mem_addr  = addr_w_q + idx_addr;
        o_mem_wdata = result;
      end
      default: ;
    endcase
  end

endmodule

// File: doc/simd_proc_ctrl.md
Name: simd_proc_ctrl

Overview:
Per-processor front-end sitting directly downstream of the command issuer; one instance per SIMD processor, wired to bit k of the issuer's enable/ack/busy/finish vectors and the shared instruction bus. It accepts the issuer's 4-instruction sequence (LD, LD, INFO, STORE) and runs a vector operation element-by-element over a single-port memory request interface. It then raises finish until the issuer acknowledges it.

Parameters:
ADDR_WIDTH, 16, memory word-address width; also the instruction payload width
DATA_WIDTH, 32, element width
COUNT_WIDTH, 8, element-count field width in INFO
OP_WIDTH, 2, opcode field width in INFO

Ports:
i_clk  in  1  clock
i_rstn  in  1  asynchronous active-low reset
i_en  in  1  issuer enable (o_en_proc[k])
i_ack  in  1  issuer acknowledge (o_ack_proc[k]); qualifies i_instr, or acknowledges finish
i_instr  in  2+ADDR_WIDTH  {type[1:0], payload}; type is INSTR_LD/INSTR_INFO/INSTR_STORE from defines.sv
o_busy  out  1  processor occupied (to i_busy_proc[k])
o_finish  out  1  task done, awaiting ack (to i_finish_proc[k])
o_error  out  1  protocol error on last task; valid while o_finish=1
o_mem_req  out  1  memory request
o_mem_we  out  1  1=write, 0=read
o_mem_addr  out  ADDR_WIDTH  word address
o_mem_wdata  out  DATA_WIDTH  write data
i_mem_gnt  in  1  request accepted this cycle
i_mem_rvalid  in  1  read data valid
i_mem_rdata  in  DATA_WIDTH  read data

Behaviour:
- Reset (async, any state): state=IDLE; all outputs 0; internal regs (addr_a, addr_b, addr_w, count, op, idx, a, b) cleared.
- States: IDLE, RX_LD0, RX_LD1, RX_INFO, RX_ST, RD_A, WA_A, RD_B, WA_B, WR, DONE.
- IDLE: o_busy=0. i_en=1 -> RX_LD0; o_busy=1 from the next cycle until DONE exits. i_ack in IDLE is ignored.
- RX_* states: advance only on i_ack=1. Each state expects one type:
  - RX_LD0: LD; addr_a=payload.
  - RX_LD1: LD; addr_b=payload.
  - RX_INFO: INFO; {count,op}=payload[ADDR_WIDTH-1 -: COUNT_WIDTH+OP_WIDTH], rest ignored.
  - RX_ST: STORE; addr_w=payload.
  - i_ack=0 holds the state indefinitely.
  - Type mismatch with i_ack=1: set error, go to DONE.
  - i_en during RX_* or EXEC is ignored.
- After RX_ST: count==0 -> DONE directly, no memory traffic. Otherwise idx=0 -> RD_A.
- RD_A: o_mem_req=1, we=0, addr=addr_a+idx.
  - Request and address are held stable until i_mem_gnt; the gnt cycle completes the request -> WA_A.
- WA_A: wait for i_mem_rvalid; latch a=i_mem_rdata -> RD_B.
  - rvalid in the gnt cycle itself is not accepted; at most one transaction is outstanding.
- RD_B/WA_B: same as RD_A/WA_A with addr_b+idx; latch b.
- WR: o_mem_req=1, we=1, addr=addr_w+idx, wdata=result, held until gnt. On gnt: idx+1; if idx+1==count -> DONE, else RD_A.
- Result by op:
  - 0: a+b
  - 1: a-b
  - 2: low DATA_WIDTH bits of a*b
  - 3: a^b
  - Arithmetic wraps modulo 2^DATA_WIDTH.
- Address arithmetic wraps modulo 2^ADDR_WIDTH. idx is COUNT_WIDTH+1 bits, so count=2^COUNT_WIDTH-1 runs fully.
- DONE: o_finish=1, o_busy=1, o_error=error flag.
  - Hold until i_ack=1, then -> IDLE, clearing o_finish, o_busy and error next cycle.
  - i_en in DONE is ignored.
- o_mem_req=0 in all states except RD_A, RD_B and WR. Outputs are registered or decoded from state only, never from i_instr combinationally.
- Latency for count=N with zero-wait memory (gnt same cycle as req, rvalid one cycle later):
  - Execution takes 5 cycles per element.
  - Finish rises 1 cycle after the last write gnt.

Test Plan:
1. Reset mid-WR with o_mem_req=1 -> next edge: o_mem_req=0, o_busy=0, o_finish=0, state IDLE; a new i_en is then accepted normally.
2. en; LD 0x0010; LD 0x0020; INFO count=3 op=0; STORE 0x0030; mem[0x10..12]={1,2,3}, mem[0x20..22]={10,20,30}, zero-wait -> writes 11,22,33 to 0x30..0x32 in order; o_finish rises, 1 cycle after i_ack o_busy=0.
3. Same sequence with op=1, a=5, b=7, count=1 -> write 0xFFFFFFFE; op=2, a=0x10000, b=0x10000 -> write 0x00000000.
4. INFO count=0 -> no o_mem_req ever asserted; o_finish=1 one cycle after STORE ack; o_error=0.
5. Protocol error: STORE-type instruction presented in RX_LD1 with i_ack=1 -> DONE with o_finish=1, o_error=1; i_ack -> IDLE, o_error=0.
6. Memory stalls (gnt delayed 3 cycles, rvalid 2 cycles after gnt); LD addr_a=0xFFFF, count=2 -> address held stable during stall; read addresses 0xFFFF then 0x0000 (wrap); extra i_en pulses during execution ignored.
